// File: rtl/assign_expr_pkg.sv
// Shared types for assign_expr_arbiter: FSM states, operation codes and index-width helper.
// The compound-add operation is only honoured when ASSIGN_EXPR_COMPOUND_EN is defined.
package assign_expr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    typedef enum logic {
        OP_ASSIGN,
        OP_ADD
    } op_e;

    localparam int unsigned MIN_IDX_W = 1;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth < 2) ? MIN_IDX_W : $clog2(depth);
    endfunction

endpackage

// File: rtl/assign_expr_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the pointer, with wrap.
// Works by rotating the request vector down by the pointer and rotating the winner back up.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] gnt_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   gnt_rot;
    logic           found;

    assign req_dbl = {req_i, req_i} >> ptr_i;
    assign req_rot = req_dbl[N-1:0];

    always_comb begin
        gnt_rot = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_rot[i]) begin
                gnt_rot[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign gnt_dbl = {gnt_rot, gnt_rot} << ptr_i;
    assign grant_o = gnt_dbl[2*N-1:N];

endmodule

// File: rtl/assign_expr_arbiter.sv
// Round-robin shared register array; each access returns the stored value (assignment-expression result).
// Define ASSIGN_EXPR_COMPOUND_EN to enable the compound-add (+=) write operation.
module assign_expr_arbiter
    import assign_expr_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0]                   req_we,
    input  logic [NUM_REQ-1:0]                   req_op,
    input  logic [NUM_REQ*idx_width(DEPTH)-1:0]  req_idx,
    input  logic [NUM_REQ*WIDTH-1:0]             req_wdata,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    input  logic [NUM_REQ-1:0]                   rsp_ready,
    output logic [WIDTH-1:0]                     rsp_data
);

    localparam int IW = idx_width(DEPTH);
    localparam int PW = $clog2(NUM_REQ);

    state_e                state_q;
    logic [PW-1:0]         ptr_q;
    logic [PW-1:0]         gnt_q;
    logic                  we_q;
    op_e                   op_q;
    logic [IW-1:0]         idx_q;
    logic [WIDTH-1:0]      wdata_q;
    logic [WIDTH-1:0]      rsp_data_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [WIDTH-1:0]      arr_q [DEPTH];

    logic [NUM_REQ-1:0]    grant_d;
    logic [PW-1:0]         gnt_id_d;
    logic [WIDTH-1:0]      wval_d;
    logic [IW-1:0]         idx_arr   [NUM_REQ];
    logic [WIDTH-1:0]      wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign idx_arr[gi]   = req_idx[gi*IW +: IW];
            assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_d)
    );

    always_comb begin
        gnt_id_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_d[i]) gnt_id_d = PW'(i);
        end
    end

`ifdef ASSIGN_EXPR_COMPOUND_EN
    assign wval_d = (op_q == OP_ADD) ? (arr_q[idx_q] + wdata_q) : wdata_q;
`else
    logic unused_op;
    assign unused_op = op_q;
    assign wval_d    = wdata_q;
`endif

    // Grant is only offered while idle; a pending response blocks all new requests.
    assign req_ready = (state_q == IDLE) ? grant_d : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            we_q        <= 1'b0;
            op_q        <= OP_ASSIGN;
            idx_q       <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) arr_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|grant_d) begin
                        gnt_q   <= gnt_id_d;
                        we_q    <= req_we[gnt_id_d];
                        op_q    <= op_e'(req_op[gnt_id_d]);
                        idx_q   <= idx_arr[gnt_id_d];
                        wdata_q <= wdata_arr[gnt_id_d];
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (we_q) begin
                        arr_q[idx_q] <= wval_d;
                        rsp_data_q   <= wval_d;
                    end else begin
                        rsp_data_q   <= arr_q[idx_q];
                    end
                    rsp_valid_q <= NUM_REQ'(1) << gnt_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt_q]) begin
                        rsp_valid_q <= '0;
                        ptr_q       <= (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assign_expr_arbiter.sv
// Self-checking bench for assign_expr_arbiter: vector table, hand sequences, randomized model check.
// Expected values follow ASSIGN_EXPR_COMPOUND_EN when the bench is built with it defined.
module tb_assign_expr_arbiter;

`ifdef ASSIGN_EXPR_COMPOUND_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_we, req_op, rsp_valid, rsp_ready;
    logic [3:0]  req_idx;
    logic [63:0] req_wdata;
    logic [31:0] rsp_data;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [4];

    typedef struct {
        int          id;
        bit          we;
        bit          op;
        int          idx;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [12];

    always #5 clk = ~clk;

    assign_expr_arbiter #(.NUM_REQ(2), .DEPTH(4), .WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    function automatic logic [1:0] oh(input int id);
        return 2'(1) << id;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int id, input bit we, input bit op, input int idx, input logic [31:0] wd);
        logic [1:0] ix;
        ix = idx[1:0];
        req_valid[id]          = 1'b1;
        req_we[id]             = we;
        req_op[id]             = op;
        req_idx[id*2 +: 2]     = ix;
        req_wdata[id*32 +: 32] = wd;
    endtask

    // Waits (bounded) for any ready, checks it against the expected grant, then takes the accept edge.
    task automatic wait_accept(input logic [1:0] mask, input string name);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) break;
        end
        chk(name, {30'd0, req_ready}, {30'd0, mask});
        @(posedge clk);
        #1;
    endtask

    // Called one step after the accept edge: EXEC cycle, then RESP, then handshake back to IDLE.
    task automatic finish_rsp(input int id, input logic [31:0] exp, input string name);
        chk({name, "_exec_valid"}, {30'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_rsp_valid"}, {30'd0, rsp_valid}, {30'd0, oh(id)});
        chk({name, "_rsp_data"}, rsp_data, exp);
        rsp_ready = oh(id);
        @(posedge clk);
        #1;
        rsp_ready = 2'b00;
        chk({name, "_done_valid"}, {30'd0, rsp_valid}, 32'd0);
    endtask

    function automatic logic [31:0] model_apply(input bit we, input bit op, input int idx, input logic [31:0] wd);
        if (we) model[idx] = (COMP && op) ? model[idx] + wd : wd;
        return model[idx];
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          last;
        int          grants;
        logic [31:0] exp;
        bit          we, op;
        int          id, idx;
        logic [31:0] wd;

        rst = 1'b1;
        req_valid = '0; req_we = '0; req_op = '0; req_idx = '0; req_wdata = '0; rsp_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);

        tbl[0]  = '{0, 1'b1, 1'b0, 0, 32'd5,         32'd5};
        tbl[1]  = '{0, 1'b0, 1'b0, 0, 32'd0,         32'd5};
        tbl[2]  = '{1, 1'b1, 1'b0, 3, 32'd100,       32'd100};
        tbl[3]  = '{0, 1'b0, 1'b0, 3, 32'd0,         32'd100};
        tbl[4]  = '{0, 1'b0, 1'b0, 1, 32'd0,         32'd0};
        tbl[5]  = '{1, 1'b0, 1'b0, 2, 32'd0,         32'd0};
        tbl[6]  = '{0, 1'b1, 1'b0, 1, 32'd3,         32'd3};
        tbl[7]  = '{0, 1'b1, 1'b1, 1, 32'd2,         COMP ? 32'd5 : 32'd2};
        tbl[8]  = '{1, 1'b1, 1'b0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[9]  = '{1, 1'b1, 1'b1, 2, 32'd1,         COMP ? 32'd0 : 32'd1};
        tbl[10] = '{0, 1'b0, 1'b0, 1, 32'd0,         COMP ? 32'd5 : 32'd2};
        tbl[11] = '{1, 1'b0, 1'b1, 2, 32'd0,         COMP ? 32'd0 : 32'd1};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].id, tbl[i].we, tbl[i].op, tbl[i].idx, tbl[i].wd);
            wait_accept(oh(tbl[i].id), $sformatf("tbl%0d_ready", i));
            req_valid = '0;
            finish_rsp(tbl[i].id, tbl[i].exp, $sformatf("tbl%0d", i));
            $display("tbl txn %0d: req%0d we=%0b op=%0b idx=%0d rsp=%0h", i, tbl[i].id, tbl[i].we, tbl[i].op, tbl[i].idx, rsp_data);
        end

        // Backpressure: response held five cycles while requester 1 waits.
        drive(0, 1'b1, 1'b0, 1, 32'd77);
        wait_accept(2'b01, "bp_ready0");
        req_valid = '0;
        drive(1, 1'b0, 1'b0, 1, 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 2'b10;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", {30'd0, rsp_valid}, 32'd1);
            chk("bp_hold_data", rsp_data, 32'd77);
            chk("bp_hold_ready", {30'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 2'b01;
        @(posedge clk);
        #1;
        rsp_ready = 2'b00;
        wait_accept(2'b10, "bp_ready1");
        req_valid = '0;
        finish_rsp(1, 32'd77, "bp_read");
        $display("backpressure txn: req1 read idx1 rsp=%0h", rsp_data);

        // Contention: both requesters always valid, responses always accepted.
        drive(0, 1'b0, 1'b0, 0, 32'd0);
        drive(1, 1'b0, 1'b0, 0, 32'd0);
        rsp_ready = 2'b11;
        last   = 1;
        grants = 0;
        for (int c = 0; c < 60 && grants < 8; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                last = (last + 1) % 2;
                chk("cont_grant", {30'd0, req_ready}, {30'd0, oh(last)});
                $display("contention grant %0d: ready=%b", grants, req_ready);
                grants++;
            end
        end
        chk("cont_count", grants, 32'd8);
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 2'b00;

        // Reset while a response is pending: r0 completes first so the pointer sits at 1.
        drive(0, 1'b0, 1'b0, 0, 32'd0);
        wait_accept(2'b01, "mr_ready0");
        req_valid = '0;
        finish_rsp(0, 32'd5, "mr_pre");
        drive(1, 1'b1, 1'b0, 2, 32'd55);
        wait_accept(2'b10, "mr_ready1");
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("mr_resp_valid", {30'd0, rsp_valid}, 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mr_valid_clr", {30'd0, rsp_valid}, 32'd0);
        chk("mr_data_clr", rsp_data, 32'd0);
        chk("mr_ready_clr", {30'd0, req_ready}, 32'd0);
        drive(0, 1'b0, 1'b0, 2, 32'd0);
        drive(1, 1'b0, 1'b0, 2, 32'd0);
        wait_accept(2'b01, "mr_ptr0");
        req_valid[0] = 1'b0;
        finish_rsp(0, 32'd0, "mr_idx2_r0");
        wait_accept(2'b10, "mr_ptr1");
        req_valid = '0;
        finish_rsp(1, 32'd0, "mr_idx2_r1");
        for (int e = 0; e < 4; e += (e == 1) ? 2 : 1) begin
            drive(0, 1'b0, 1'b0, e, 32'd0);
            wait_accept(2'b01, "mr_clr_ready");
            req_valid = '0;
            finish_rsp(0, 32'd0, $sformatf("mr_clr_idx%0d", e));
            $display("post-reset read idx%0d rsp=%0h", e, rsp_data);
        end

        // Randomized transactions against the array model (array is all zero after the reset).
        for (int e = 0; e < 4; e++) model[e] = '0;
        for (int t = 0; t < 40; t++) begin
            id  = int'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            op  = 1'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 3));
            wd  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            exp = model_apply(we, op, idx, wd);
            drive(id, we, op, idx, wd);
            wait_accept(oh(id), "rnd_ready");
            req_valid = '0;
            finish_rsp(id, exp, $sformatf("rnd%0d", t));
            $display("rnd txn %0d: req%0d we=%0b op=%0b idx=%0d wd=%0h rsp=%0h", t, id, we, op, idx, wd, rsp_data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
